// File: rtl/sub_pipd.sv
// Pipelined unsigned subtractor: STAGES borrow-chain chunks with valid/ready flow control.
// Each stage resolves one CHUNK of the difference and forwards only the bits still needed.
module sub_pipd #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sub_in_valid,
    output logic             sub_in_ready,
    input  logic [WIDTH-1:0] sub_minuend,
    input  logic [WIDTH-1:0] sub_subtrahend,
    output logic             sub_out_valid,
    input  logic             sub_out_ready,
    output logic [WIDTH-1:0] sub_out,
    output logic             sub_borrow
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    // Packed storage: stage k keeps (k+1) finished result chunks and WIDTH-(k+1)*CHUNK
    // unprocessed operand bits; the last stage keeps no operands (STAGES >= 2 assumed).
    localparam int unsigned RES_TOT = CHUNK * STAGES * (STAGES + 1) / 2;
    localparam int unsigned OPS_TOT = CHUNK * STAGES * (STAGES - 1) / 2;

    logic [RES_TOT-1:0] res_q, res_d;
    logic [OPS_TOT-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [STAGES-1:0]  vld_q, vld_d, brw_q, brw_d;
    logic               stall;

    assign stall        = vld_q[STAGES-1] && !sub_out_ready;
    assign sub_in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned ResOff = CHUNK * k * (k + 1) / 2;
        localparam int unsigned ResW   = (k + 1) * CHUNK;
        localparam int unsigned RemW   = WIDTH - ResW;

        logic [CHUNK-1:0] a_chunk, b_chunk;
        logic             borrow_in;
        logic [CHUNK:0]   diff;

        if (k == 0) begin : g_src
            assign a_chunk   = sub_minuend[CHUNK-1:0];
            assign b_chunk   = sub_subtrahend[CHUNK-1:0];
            assign borrow_in = 1'b0;
            assign vld_d[k]  = sub_in_valid;
            assign res_d[ResOff +: ResW] = diff[CHUNK-1:0];
        end else begin : g_src
            localparam int unsigned PrevOpsOff = (k - 1) * WIDTH - CHUNK * (k - 1) * k / 2;
            localparam int unsigned PrevResOff = CHUNK * (k - 1) * k / 2;
            assign a_chunk   = opa_q[PrevOpsOff +: CHUNK];
            assign b_chunk   = opb_q[PrevOpsOff +: CHUNK];
            assign borrow_in = brw_q[k-1];
            assign vld_d[k]  = vld_q[k-1];
            assign res_d[ResOff +: ResW] = {diff[CHUNK-1:0], res_q[PrevResOff +: k * CHUNK]};
        end

        // CHUNK+1 bit subtraction: the top bit is the chunk's borrow-out.
        assign diff     = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_in};
        assign brw_d[k] = diff[CHUNK];

        if (k < STAGES - 1) begin : g_ops
            localparam int unsigned OpsOff = k * WIDTH - CHUNK * k * (k + 1) / 2;
            if (k == 0) begin : g_fwd
                assign opa_d[OpsOff +: RemW] = sub_minuend[WIDTH-1:CHUNK];
                assign opb_d[OpsOff +: RemW] = sub_subtrahend[WIDTH-1:CHUNK];
            end else begin : g_fwd
                localparam int unsigned PrevOff = (k - 1) * WIDTH - CHUNK * (k - 1) * k / 2;
                assign opa_d[OpsOff +: RemW] = opa_q[PrevOff + CHUNK +: RemW];
                assign opb_d[OpsOff +: RemW] = opb_q[PrevOff + CHUNK +: RemW];
            end
        end
    end

    // Global stall: every stage, bubbles included, holds while the output waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            brw_q <= '0;
            res_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (!stall) begin
            vld_q <= vld_d;
            brw_q <= brw_d;
            res_q <= res_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
        end
    end

    assign sub_out_valid = vld_q[STAGES-1];
    assign sub_borrow    = brw_q[STAGES-1];
    assign sub_out       = res_q[RES_TOT-1 -: WIDTH];

endmodule

// File: tb/tb_sub_pipd.sv
// Self-checking bench for sub_pipd: randomized operands against a plain-arithmetic model.
module tb_sub_pipd;

    localparam int unsigned W = 64;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sub_in_valid = 1'b0;
    logic         sub_in_ready;
    logic [W-1:0] sub_minuend = '0;
    logic [W-1:0] sub_subtrahend = '0;
    logic         sub_out_valid;
    logic         sub_out_ready = 1'b1;
    logic [W-1:0] sub_out;
    logic         sub_borrow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sub_pipd #(.WIDTH(W), .STAGES(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sub_in_valid   (sub_in_valid),
        .sub_in_ready   (sub_in_ready),
        .sub_minuend    (sub_minuend),
        .sub_subtrahend (sub_subtrahend),
        .sub_out_valid  (sub_out_valid),
        .sub_out_ready  (sub_out_ready),
        .sub_out        (sub_out),
        .sub_borrow     (sub_borrow)
    );

    always #5 clk = ~clk;

    // Reference: {borrow, difference} straight from unsigned arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (sub_out_valid !== 1'b0 || sub_out !== '0 || sub_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b out=%h b=%b, expected v=0 out=0 b=0",
                     sub_out_valid, sub_out, sub_borrow);
        end
        n_checks++;
        if (sub_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 1", sub_in_ready);
        end
        rst_n = 1'b1;
        sub_out_ready = 1'b1;
        tick();
        // i - (i+1) underflows, so the result at the output is nonzero with borrow set.
        for (int i = 0; i < 4; i++) begin
            sub_in_valid   = 1'b1;
            sub_minuend    = W'(i);
            sub_subtrahend = W'(i + 1);
            tick();
        end
        sub_in_valid = 1'b0;
        #1;
        n_checks++;
        if (sub_out_valid !== 1'b1 || sub_out !== {W{1'b1}} || sub_borrow !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_result: got v=%b out=%h b=%b, expected v=1 out=%h b=1",
                     sub_out_valid, sub_out, sub_borrow, {W{1'b1}});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sub_out_valid !== 1'b0 || sub_out !== '0 || sub_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b out=%h b=%b, expected v=0 out=0 b=0",
                     sub_out_valid, sub_out, sub_borrow);
        end
        n_checks++;
        if (sub_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_ready: got %b, expected 1", sub_in_ready);
        end
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (sub_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet: cycle %0d got valid=%b, expected 0",
                         i, sub_out_valid);
            end
        end
    endtask

    task automatic test_single();
        sub_out_ready  = 1'b1;
        sub_in_valid   = 1'b1;
        sub_minuend    = W'(1000);
        sub_subtrahend = W'(1);
        #1;
        n_checks++;
        if (sub_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b, expected 1", sub_in_ready);
        end
        tick();
        sub_in_valid = 1'b0;
        for (int n = 1; n <= int'(S); n++) begin
            #1;
            n_checks++;
            if (sub_out_valid !== (n == int'(S))) begin
                n_fail++;
                $display("FAIL single_latency: after edge %0d got valid=%b, expected %b",
                         n, sub_out_valid, (n == int'(S)));
            end
            if (n < int'(S)) tick();
        end
        n_checks++;
        if (sub_out !== W'(999) || sub_borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL single_value: got out=%0d b=%b, expected out=999 b=0",
                     sub_out, sub_borrow);
        end
        tick();
        #1;
        n_checks++;
        if (sub_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_dup: got valid=%b, expected 0", sub_out_valid);
        end
    endtask

    task automatic test_inverse();
        logic [W-1:0] a[6], b[6], m[6];
        int sent = 0, got = 0;
        for (int i = 0; i < 5; i++) begin
            a[i] = rand64();
            b[i] = rand64();
            m[i] = a[i] + b[i];
        end
        a[5] = 64'h0000_0000_FFFF_FFFF;
        b[5] = 64'd1;
        m[5] = 64'h0000_0001_0000_0000;
        sub_out_ready = 1'b1;
        for (int g = 0; g < 40 && got < 6; g++) begin
            sub_in_valid = (sent < 6);
            if (sent < 6) begin
                sub_minuend    = m[sent];
                sub_subtrahend = b[sent];
            end
            #1;
            if (sub_out_valid) begin
                logic [W:0] e;
                e = model(m[got], b[got]);
                n_checks++;
                if (sub_out !== a[got] || sub_borrow !== e[W]) begin
                    n_fail++;
                    $display("FAIL inverse[%0d]: got out=%h b=%b, expected out=%h b=%b",
                             got, sub_out, sub_borrow, a[got], e[W]);
                end
                got++;
            end
            if (sub_in_valid && sub_in_ready) sent++;
            tick();
        end
        sub_in_valid = 1'b0;
        n_checks++;
        if (got != 6) begin
            n_fail++;
            $display("FAIL inverse_count: got %0d results, expected 6", got);
        end
    endtask

    task automatic test_underflow();
        logic [W-1:0] mi[3], su[3], ex[3];
        logic         eb[3];
        int sent = 0, got = 0;
        mi[0] = 64'd0; su[0] = 64'd1; ex[0] = 64'hFFFF_FFFF_FFFF_FFFF; eb[0] = 1'b1;
        mi[1] = 64'd5; su[1] = 64'd5; ex[1] = 64'd0;                   eb[1] = 1'b0;
        mi[2] = 64'h0000_0001_0000_0000; su[2] = 64'd1;
        ex[2] = 64'h0000_0000_FFFF_FFFF; eb[2] = 1'b0;
        sub_out_ready = 1'b1;
        for (int g = 0; g < 30 && got < 3; g++) begin
            sub_in_valid = (sent < 3);
            if (sent < 3) begin
                sub_minuend    = mi[sent];
                sub_subtrahend = su[sent];
            end
            #1;
            if (sub_out_valid) begin
                n_checks++;
                if (sub_out !== ex[got] || sub_borrow !== eb[got]) begin
                    n_fail++;
                    $display("FAIL underflow[%0d]: got out=%h b=%b, expected out=%h b=%b",
                             got, sub_out, sub_borrow, ex[got], eb[got]);
                end
                got++;
            end
            if (sub_in_valid && sub_in_ready) sent++;
            tick();
        end
        sub_in_valid = 1'b0;
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL underflow_count: got %0d results, expected 3", got);
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0, got = 0, stall_left = 0;
        for (int g = 0; g < 60 && got < 8; g++) begin
            logic stalled;
            stalled        = (stall_left > 0);
            sub_out_ready  = !stalled;
            sub_in_valid   = (sent < 8);
            sub_minuend    = W'(sent + 1);
            sub_subtrahend = W'(1);
            #1;
            if (stalled) begin
                n_checks++;
                if (sub_in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %b, expected 0", sub_in_ready);
                end
                n_checks++;
                if (sub_out_valid !== 1'b1 || sub_out !== W'(2) || sub_borrow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: got v=%b out=%0d b=%b, expected v=1 out=2 b=0",
                             sub_out_valid, sub_out, sub_borrow);
                end
                stall_left--;
            end else if (sub_out_valid) begin
                n_checks++;
                if (sub_out !== W'(got) || sub_borrow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got out=%0d b=%b, expected out=%0d b=0",
                             got, sub_out, sub_borrow, got);
                end
                got++;
                if (got == 2) stall_left = 3;
            end
            if (sub_in_valid && sub_in_ready) sent++;
            tick();
        end
        sub_in_valid  = 1'b0;
        sub_out_ready = 1'b1;
        n_checks++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, expected 8", got);
        end
        #1;
        n_checks++;
        if (sub_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_extra: got valid=%b after last result, expected 0", sub_out_valid);
        end
    endtask

    task automatic test_throughput();
        logic [W-1:0] a[16], b[16];
        int sent = 0, got = 0, first_acc = -1;
        for (int i = 0; i < 16; i++) begin
            a[i] = rand64();
            b[i] = rand64();
        end
        sub_out_ready = 1'b1;
        for (int g = 0; g < 60 && got < 16; g++) begin
            sub_in_valid = (sent < 16);
            if (sent < 16) begin
                sub_minuend    = a[sent];
                sub_subtrahend = b[sent];
            end
            #1;
            if (sub_out_valid) begin
                logic [W:0] e;
                e = model(a[got], b[got]);
                n_checks++;
                if (sub_out !== e[W-1:0] || sub_borrow !== e[W]) begin
                    n_fail++;
                    $display("FAIL tput_value[%0d]: got out=%h b=%b, expected out=%h b=%b",
                             got, sub_out, sub_borrow, e[W-1:0], e[W]);
                end
                n_checks++;
                if (cyc != first_acc + int'(S) + got) begin
                    n_fail++;
                    $display("FAIL tput_timing[%0d]: got cycle %0d, expected %0d",
                             got, cyc, first_acc + int'(S) + got);
                end
                got++;
            end
            if (sub_in_valid && sub_in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            tick();
        end
        sub_in_valid = 1'b0;
        n_checks++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL tput_count: got %0d results, expected 16", got);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_inverse();
        test_underflow();
        test_back_pressure();
        test_throughput();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
